moore_output_stage: RTL and testbench

Downstream consumer of the two-bit Moore state register stage. Samples the present-state code (y1, y2) each clock, produces the registered Moore output Z, a one-cycle detection pulse on each entry into the detect state, and a saturating detection-event counter. Each counted event is reported to a host through a valid/ready handshake, and an event overwritten before acceptance is flagged.

---
 rtl/moore_output_stage.sv | 117 +++++++++++
 tb/tb_moore_output_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/moore_output_stage.sv
// moore_output_stage: registered Moore output, entry pulse, saturating
// event counter and a single-entry valid/ready snapshot towards a host.
module moore_output_stage #(
  parameter int         CNT_W       = 8,
  parameter logic [1:0] DETECT_CODE = 2'b11
) (
  input  logic             inputClk,
  input  logic             inputR,
  input  logic             inputy1,
  input  logic             inputy2,
  input  logic             inputClr,
  input  logic             inputReady,
  output logic             outputZ,
  output logic             outputPulse,
  output logic [CNT_W-1:0] outputCount,
  output logic             outputSat,
  output logic             outputValid,
  output logic [CNT_W-1:0] outputData,
  output logic             outputDrop
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             det_s;
  logic             ev_s;
  logic             xfer_s;
  logic [CNT_W-1:0] cnt_inc_s;

  logic             z_d, z_q;
  logic             pulse_d, pulse_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             sat_d, sat_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] data_d, data_q;
  logic             drop_d, drop_q;

  // Decode the present state, detect entries and compute all next-state values.
  always_comb begin
    det_s  = ({inputy1, inputy2} == DETECT_CODE);
    ev_s   = det_s & ~z_q;
    xfer_s = valid_q & inputReady;

    // Counter holds at its maximum instead of wrapping.
    if (count_q == CNT_MAX) begin
      cnt_inc_s = CNT_MAX;
    end else begin
      cnt_inc_s = count_q + CNT_ONE;
    end

    z_d     = det_s;
    pulse_d = ev_s;
    count_d = count_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    data_d  = data_q;
    drop_d  = drop_q;

    if (inputClr) begin
      // Clear wins over a coincident entry; the snapshot value itself is kept.
      count_d = CNT_ZERO;
      sat_d   = 1'b0;
      valid_d = 1'b0;
      drop_d  = 1'b0;
    end else if (ev_s) begin
      count_d = cnt_inc_s;
      data_d  = cnt_inc_s;
      valid_d = 1'b1;
      if (cnt_inc_s == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        sat_d = sat_q;
      end
      // A pending snapshot not being accepted this edge is lost.
      if (valid_q & ~inputReady) begin
        drop_d = 1'b1;
      end else begin
        drop_d = drop_q;
      end
    end else if (xfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge inputClk) begin
    if (inputR) begin
      z_q     <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= CNT_ZERO;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= CNT_ZERO;
      drop_q  <= 1'b0;
    end else begin
      z_q     <= z_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign outputZ     = z_q;
  assign outputPulse = pulse_q;
  assign outputCount = count_q;
  assign outputSat   = sat_q;
  assign outputValid = valid_q;
  assign outputData  = data_q;
  assign outputDrop  = drop_q;

endmodule

// File: tb/tb_moore_output_stage.sv
// Bench for moore_output_stage: directed vector table, a saturation sequence
// on a narrow-counter instance, and random stimulus against a reference model.
module tb_moore_output_stage;

  logic       inputClk = 1'b0;
  logic       inputR = 1'b1;
  logic       inputy1 = 1'b0;
  logic       inputy2 = 1'b0;
  logic       inputClr = 1'b0;
  logic       inputReady = 1'b0;

  logic       z8, p8, sat8, v8, drop8;
  logic [7:0] cnt8, data8;
  logic       z2, p2, sat2, v2, drop2;
  logic [1:0] cnt2, data2;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state, index 0 = 8-bit counter, index 1 = 2-bit counter
  int m_z = 0;
  int m_p = 0;
  int m_cnt[2] = '{0, 0};
  int m_sat[2] = '{0, 0};
  int m_val[2] = '{0, 0};
  int m_dat[2] = '{0, 0};
  int m_drp[2] = '{0, 0};
  int m_max[2] = '{255, 3};

  typedef struct {
    logic       r, clr, rdy;
    logic [1:0] code;
    int         z, p, c, sat, v, d, drop;
  } vec_t;

  vec_t vecs[$];

  moore_output_stage #(.CNT_W(8)) dut8 (
    .inputClk(inputClk), .inputR(inputR), .inputy1(inputy1), .inputy2(inputy2),
    .inputClr(inputClr), .inputReady(inputReady),
    .outputZ(z8), .outputPulse(p8), .outputCount(cnt8), .outputSat(sat8),
    .outputValid(v8), .outputData(data8), .outputDrop(drop8)
  );

  moore_output_stage #(.CNT_W(2)) dut2 (
    .inputClk(inputClk), .inputR(inputR), .inputy1(inputy1), .inputy2(inputy2),
    .inputClr(inputClr), .inputReady(inputReady),
    .outputZ(z2), .outputPulse(p2), .outputCount(cnt2), .outputSat(sat2),
    .outputValid(v2), .outputData(data2), .outputDrop(drop2)
  );

  always #5 inputClk = ~inputClk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Event-level model: entry = detect code seen while previous output was low.
  task automatic model_update(input logic r, input logic clr, input logic rdy, input logic [1:0] code);
    int det;
    int entry;
    det = (code == 2'b11) ? 1 : 0;
    entry = (det == 1 && m_z == 0) ? 1 : 0;
    if (r) begin
      m_z = 0;
      m_p = 0;
      for (int w = 0; w < 2; w++) begin
        m_cnt[w] = 0; m_sat[w] = 0; m_val[w] = 0; m_dat[w] = 0; m_drp[w] = 0;
      end
    end else begin
      m_z = det;
      m_p = entry;
      for (int w = 0; w < 2; w++) begin
        if (clr) begin
          m_cnt[w] = 0; m_sat[w] = 0; m_val[w] = 0; m_drp[w] = 0;
        end else if (entry == 1) begin
          if (m_cnt[w] < m_max[w]) m_cnt[w] = m_cnt[w] + 1;
          if (m_cnt[w] == m_max[w]) m_sat[w] = 1;
          if (m_val[w] == 1 && !rdy) m_drp[w] = 1;
          m_dat[w] = m_cnt[w];
          m_val[w] = 1;
        end else if (m_val[w] == 1 && rdy) begin
          m_val[w] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic clr, input logic rdy, input logic [1:0] code);
    inputR = r;
    inputClr = clr;
    inputReady = rdy;
    inputy1 = code[1];
    inputy2 = code[0];
    @(posedge inputClk);
    model_update(r, clr, rdy, code);
    #1;
  endtask

  task automatic check_model();
    check("m8_z", int'(z8), m_z);
    check("m8_pulse", int'(p8), m_p);
    check("m8_count", int'(cnt8), m_cnt[0]);
    check("m8_sat", int'(sat8), m_sat[0]);
    check("m8_valid", int'(v8), m_val[0]);
    check("m8_data", int'(data8), m_dat[0]);
    check("m8_drop", int'(drop8), m_drp[0]);
    check("m2_z", int'(z2), m_z);
    check("m2_pulse", int'(p2), m_p);
    check("m2_count", int'(cnt2), m_cnt[1]);
    check("m2_sat", int'(sat2), m_sat[1]);
    check("m2_valid", int'(v2), m_val[1]);
    check("m2_data", int'(data2), m_dat[1]);
    check("m2_drop", int'(drop2), m_drp[1]);
  endtask

  function automatic vec_t mk(input logic r, input logic clr, input logic rdy, input logic [1:0] code,
                              input int z, input int p, input int c, input int sat,
                              input int v, input int d, input int drop);
    vec_t t;
    t.r = r; t.clr = clr; t.rdy = rdy; t.code = code;
    t.z = z; t.p = p; t.c = c; t.sat = sat; t.v = v; t.d = d; t.drop = drop;
    return t;
  endfunction

  initial begin
    //              r     clr   rdy   code   z  p  c  s  v  d  drop
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 0, 0, 0, 0, 0, 0, 0)); // reset held with detect code
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'b11, 1, 1, 1, 0, 1, 1, 0)); // first edge after reset counts
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b00, 0, 0, 1, 0, 0, 1, 0)); // accepted
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b00, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b11, 1, 1, 2, 0, 1, 2, 0)); // held detect: one pulse
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b11, 1, 0, 2, 0, 0, 2, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b11, 1, 0, 2, 0, 0, 2, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b01, 0, 0, 2, 0, 0, 2, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b11, 1, 1, 3, 0, 1, 3, 0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 0, 3, 0)); // clear keeps data
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'b11, 1, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'b11, 1, 1, 2, 0, 1, 2, 1)); // overwrite -> drop
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b00, 0, 0, 2, 0, 0, 2, 1)); // accept, data held
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'b11, 1, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b11, 1, 1, 2, 0, 1, 2, 0)); // accept + entry same edge
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 2, 0, 1, 2, 0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 2'b11, 1, 1, 0, 0, 0, 2, 0)); // clear on entry edge
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'b11, 1, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0)); // reset mid-handshake
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0));

    #2;
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].clr, vecs[i].rdy, vecs[i].code);
      check($sformatf("v%0d_z", i), int'(z8), vecs[i].z);
      check($sformatf("v%0d_pulse", i), int'(p8), vecs[i].p);
      check($sformatf("v%0d_count", i), int'(cnt8), vecs[i].c);
      check($sformatf("v%0d_sat", i), int'(sat8), vecs[i].sat);
      check($sformatf("v%0d_valid", i), int'(v8), vecs[i].v);
      check($sformatf("v%0d_data", i), int'(data8), vecs[i].d);
      check($sformatf("v%0d_drop", i), int'(drop8), vecs[i].drop);
    end

    // Saturation on the 2-bit instance: five entries from a clean state.
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 2'b11);
      check($sformatf("sat_e%0d_count", k), int'(cnt2), (k < 3) ? k : 3);
      check($sformatf("sat_e%0d_sat", k), int'(sat2), (k >= 3) ? 1 : 0);
      check($sformatf("sat_e%0d_data", k), int'(data2), (k < 3) ? k : 3);
      check($sformatf("sat_e%0d_pulse", k), int'(p2), 1);
      check($sformatf("sat_e%0d_valid", k), int'(v2), 1);
      step(1'b0, 1'b0, 1'b1, 2'b00);
      check($sformatf("sat_g%0d_pulse", k), int'(p2), 0);
    end

    // Random traffic with occasional reset and clear.
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(63) == 0), ($urandom_range(31) == 0),
           1'($urandom_range(1)), 2'($urandom_range(3)));
      check_model();
    end

    // Long random run without clear so the 8-bit counter reaches saturation.
    for (int n = 0; n < 2500; n++) begin
      step(1'b0, 1'b0, 1'($urandom_range(1)), 2'($urandom_range(3)));
      check_model();
    end
    check("sat8_reached", int'(sat8), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
